// File: rtl/pipeline_perf_monitor_if.sv
// Status/readback bundle between the CPU core and its performance monitor.
// The master drives per-cycle pipeline events and read requests; the slave answers.
interface pipeline_perf_monitor_if #(
  parameter int CNT_W = 32
);
  logic             start_i;
  logic             stall_i;
  logic             branch_i;
  logic             flush_i;
  logic             retire_i;
  logic             clear_i;
  logic [1:0]       rd_sel_i;
  logic             rd_req_i;
  logic             rd_vld_o;
  logic [CNT_W-1:0] rd_data_o;
  logic             running_o;
  logic             done_o;
  logic             ovf_o;

  modport master (
    output start_i, stall_i, branch_i, flush_i, retire_i, clear_i, rd_sel_i, rd_req_i,
    input  rd_vld_o, rd_data_o, running_o, done_o, ovf_o
  );

  modport slave (
    input  start_i, stall_i, branch_i, flush_i, retire_i, clear_i, rd_sel_i, rd_req_i,
    output rd_vld_o, rd_data_o, running_o, done_o, ovf_o
  );
endinterface

// File: rtl/pipeline_perf_monitor.sv
// Saturating cycle/stall/flush/retire event counters for the 5-stage core,
// gated by an IDLE/RUN/HOLD/DONE run-control FSM, with a registered snapshot read port.
module pipeline_perf_monitor #(
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  pipeline_perf_monitor_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

  localparam int CMP_W = CNT_W + 32;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt [4];   // 0=cycles 1=stalls 2=flushes 3=retired
  logic [3:0]       inc;
  logic [3:0]       full;
  logic [CMP_W-1:0] cyc_plus1;
  logic             cyc_hit;
  logic             ovf;
  logic             rd_vld;
  logic [CNT_W-1:0] rd_data;
  logic             running;
  logic             done;

  // A stall raised together with a branch is the branch bubble, not a hazard stall.
  assign inc = {bus.retire_i, bus.flush_i, bus.stall_i & ~bus.branch_i, 1'b1};

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    full = '0;
    for (int i = 0; i < 4; i++) full[i] = &cnt[i];
  end

  // Widened compare so a MAX_CYCLES beyond the counter range simply never fires.
  assign cyc_plus1 = CMP_W'(cnt[0]) + CMP_W'(1);
  assign cyc_hit   = (MAX_CYCLES != 0) && !full[0] && (cyc_plus1 == CMP_W'(MAX_CYCLES));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (bus.clear_i) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start_i) state_next = RUN;
        RUN:     if (cyc_hit) state_next = DONE;
                 else if (!bus.start_i) state_next = HOLD;
        HOLD:    if (bus.start_i) state_next = RUN;
        default: state_next = state;
      endcase
    end
  end

  always_comb begin
    running = 1'b0;
    done    = 1'b0;
    case (state)
      RUN:     running = 1'b1;
      DONE:    done    = 1'b1;
      default: ;
    endcase
  end

  // NOTE: the counter array is a handful of flops, not a RAM, so it is cleared by the async reset like any register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
      ovf <= 1'b0;
    end else if (bus.clear_i) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
      ovf <= 1'b0;
    end else if (state == RUN) begin
      for (int i = 0; i < 4; i++) begin
        if (inc[i] && !full[i]) cnt[i] <= cnt[i] + CNT_W'(1);
      end
      if (|(inc & full)) ovf <= 1'b1;
    end
  end

  // Snapshot reflects the counters before this edge's update, and survives clear.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_vld  <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_vld <= bus.rd_req_i;
      if (bus.rd_req_i) rd_data <= cnt[bus.rd_sel_i];
    end
  end

  assign bus.rd_vld_o  = rd_vld;
  assign bus.rd_data_o = rd_data;
  assign bus.running_o = running;
  assign bus.done_o    = done;
  assign bus.ovf_o     = ovf;

endmodule

// File: tb/tb_pipeline_perf_monitor.sv
// Directed bench for pipeline_perf_monitor: a per-cycle vector table on a 32-bit,
// MAX_CYCLES=64 instance plus hand sequences for hold, run limit, saturation and reset.
module tb_pipeline_perf_monitor;

  logic clk_i = 1'b0;
  logic rst_i;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk_i = ~clk_i;

  pipeline_perf_monitor_if #(.CNT_W(32)) bus   ();
  pipeline_perf_monitor_if #(.CNT_W(4))  bus_s ();

  pipeline_perf_monitor #(.CNT_W(32), .MAX_CYCLES(64)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  pipeline_perf_monitor #(.CNT_W(4), .MAX_CYCLES(0)) dut_s (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus_s)
  );

  typedef struct {
    logic        start, stall, branch, flush, retire, clear, rd_req;
    logic [1:0]  rd_sel;
    logic        exp_vld;
    logic [31:0] exp_data;
    logic        exp_run;
    logic        exp_done;
  } vec_t;

  vec_t vecs [26];

  function automatic vec_t mk(input logic st, sl, br, fl, rt, cl, rq, input logic [1:0] sel,
                              input logic ev, input logic [31:0] ed, input logic er, input logic edn);
    vec_t x;
    x.start = st; x.stall = sl; x.branch = br; x.flush = fl; x.retire = rt;
    x.clear = cl; x.rd_req = rq; x.rd_sel = sel;
    x.exp_vld = ev; x.exp_data = ed; x.exp_run = er; x.exp_done = edn;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic st, sl, br, fl, rt, cl, rq, input logic [1:0] sel);
    bus.start_i = st; bus.stall_i = sl; bus.branch_i = br; bus.flush_i = fl;
    bus.retire_i = rt; bus.clear_i = cl; bus.rd_req_i = rq; bus.rd_sel_i = sel;
  endtask

  task automatic drive_s(input logic st, rt, cl, rq, input logic [1:0] sel);
    bus_s.start_i = st; bus_s.stall_i = 1'b0; bus_s.branch_i = 1'b0; bus_s.flush_i = 1'b0;
    bus_s.retire_i = rt; bus_s.clear_i = cl; bus_s.rd_req_i = rq; bus_s.rd_sel_i = sel;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " rd_vld"},  32'(bus.rd_vld_o),  32'd0);
    check({tag, " rd_data"}, bus.rd_data_o,      32'd0);
    check({tag, " running"}, 32'(bus.running_o), 32'd0);
    check({tag, " done"},    32'(bus.done_o),    32'd0);
    check({tag, " ovf"},     32'(bus.ovf_o),     32'd0);
  endtask

  initial begin
    int k;
    //        st sl br fl rt cl rq sel  vld data run done
    vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0,  1, 0);  // IDLE->RUN, not counted
    vecs[1]  = mk(1, 1, 0, 0, 0, 0, 0, 2'd0, 0, 0,  1, 0);  // hazard stalls x3
    vecs[2]  = mk(1, 1, 0, 0, 0, 0, 0, 2'd0, 0, 0,  1, 0);
    vecs[3]  = mk(1, 1, 0, 0, 0, 0, 0, 2'd0, 0, 0,  1, 0);
    vecs[4]  = mk(1, 1, 1, 0, 0, 0, 0, 2'd0, 0, 0,  1, 0);  // branch bubbles x2
    vecs[5]  = mk(1, 1, 1, 0, 0, 0, 0, 2'd0, 0, 0,  1, 0);
    vecs[6]  = mk(1, 0, 0, 0, 0, 0, 1, 2'd1, 1, 3,  1, 0);  // stalls = 3
    vecs[7]  = mk(1, 0, 0, 0, 0, 1, 1, 2'd0, 1, 6,  0, 0);  // read with clear: pre-clear cycles
    vecs[8]  = mk(1, 0, 0, 0, 0, 0, 1, 2'd0, 1, 0,  1, 0);  // post-clear read is 0
    vecs[9]  = mk(1, 1, 0, 1, 1, 0, 0, 2'd0, 0, 0,  1, 0);  // flush+retire x5, stall once
    vecs[10] = mk(1, 0, 0, 1, 1, 0, 0, 2'd0, 0, 0,  1, 0);
    vecs[11] = mk(1, 0, 0, 1, 1, 0, 0, 2'd0, 0, 0,  1, 0);
    vecs[12] = mk(1, 0, 0, 1, 1, 0, 0, 2'd0, 0, 0,  1, 0);
    vecs[13] = mk(1, 0, 0, 1, 1, 0, 0, 2'd0, 0, 0,  1, 0);
    vecs[14] = mk(1, 0, 0, 0, 0, 0, 1, 2'd2, 1, 5,  1, 0);  // flushes
    vecs[15] = mk(1, 0, 0, 0, 0, 0, 1, 2'd3, 1, 5,  1, 0);  // retired
    vecs[16] = mk(1, 0, 0, 0, 0, 0, 1, 2'd1, 1, 1,  1, 0);  // stalls
    vecs[17] = mk(1, 0, 0, 0, 0, 0, 1, 2'd0, 1, 8,  1, 0);  // cycles
    vecs[18] = mk(1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 8,  1, 0);  // data holds
    vecs[19] = mk(0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 8,  0, 0);  // RUN->HOLD, last counted cycle
    vecs[20] = mk(0, 1, 0, 1, 1, 0, 1, 2'd0, 1, 11, 0, 0);  // events ignored in HOLD
    vecs[21] = mk(0, 0, 0, 1, 1, 0, 1, 2'd2, 1, 5,  0, 0);
    vecs[22] = mk(1, 0, 0, 0, 0, 0, 1, 2'd0, 1, 11, 1, 0);  // HOLD->RUN, not counted
    vecs[23] = mk(1, 0, 0, 0, 0, 0, 1, 2'd0, 1, 11, 1, 0);
    vecs[24] = mk(1, 0, 0, 0, 0, 0, 1, 2'd0, 1, 12, 1, 0);
    vecs[25] = mk(1, 0, 0, 0, 0, 0, 1, 2'd3, 1, 5,  1, 0);

    rst_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 2'd0);
    drive_s(0, 0, 0, 0, 2'd0);
    #12;
    check_zero("reset");
    #10 rst_i = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].start, vecs[i].stall, vecs[i].branch, vecs[i].flush, vecs[i].retire,
            vecs[i].clear, vecs[i].rd_req, vecs[i].rd_sel);
      tick();
      check($sformatf("vec%0d rd_vld", i),  32'(bus.rd_vld_o),  32'(vecs[i].exp_vld));
      check($sformatf("vec%0d rd_data", i), bus.rd_data_o,      vecs[i].exp_data);
      check($sformatf("vec%0d running", i), 32'(bus.running_o), 32'(vecs[i].exp_run));
      check($sformatf("vec%0d done", i),    32'(bus.done_o),    32'(vecs[i].exp_done));
      check($sformatf("vec%0d ovf", i),     32'(bus.ovf_o),     32'd0);
    end

    // Hold for 10 cycles mid-run: cycles was 14, the drop cycle counts as 15.
    drive(0, 0, 0, 0, 0, 0, 0, 2'd0);
    tick();
    check("hold entry running", 32'(bus.running_o), 32'd0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 0, 1, 1, 0, 0, 2'd0);
      tick();
      check($sformatf("hold%0d running", i), 32'(bus.running_o), 32'd0);
    end
    drive(1, 0, 0, 0, 0, 0, 1, 2'd0);
    tick();
    check("hold cycles", bus.rd_data_o, 32'd15);
    check("resume running", 32'(bus.running_o), 32'd1);
    tick();
    check("resume first read", bus.rd_data_o, 32'd15);
    tick();
    check("resume counting", bus.rd_data_o, 32'd16);

    // Run limit: 64 counted RUN cycles then DONE.
    drive(0, 0, 0, 0, 0, 1, 0, 2'd0);
    tick();
    check("limit clear running", 32'(bus.running_o), 32'd0);
    drive(1, 0, 0, 0, 0, 0, 0, 2'd0);
    tick();
    check("limit enter run", 32'(bus.running_o), 32'd1);
    k = 1;
    while (k <= 200) begin
      tick();
      if (bus.done_o) break;
      k++;
    end
    check("limit cycles to done", 32'(k), 32'd64);
    check("limit running off", 32'(bus.running_o), 32'd0);
    drive(1, 0, 0, 0, 0, 0, 1, 2'd0);
    tick();
    check("limit read cycles", bus.rd_data_o, 32'd64);
    drive(0, 1, 0, 1, 1, 0, 1, 2'd0);
    tick();
    check("done frozen cycles", bus.rd_data_o, 32'd64);
    check("done sticky", 32'(bus.done_o), 32'd1);
    drive(1, 0, 0, 0, 0, 0, 1, 2'd3);
    tick();
    check("done frozen retired", bus.rd_data_o, 32'd0);
    check("done start ignored", 32'(bus.done_o), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 2'd0);

    // Saturation on the 4-bit instance.
    drive_s(1, 0, 0, 0, 2'd0);
    tick();
    for (int i = 0; i < 20; i++) begin
      drive_s(1, 1, 0, 0, 2'd0);
      tick();
    end
    drive_s(1, 0, 0, 1, 2'd3);
    tick();
    check("sat retired", 32'(bus_s.rd_data_o), 32'd15);
    check("sat ovf", 32'(bus_s.ovf_o), 32'd1);
    drive_s(1, 0, 1, 0, 2'd0);
    tick();
    check("sat clear ovf", 32'(bus_s.ovf_o), 32'd0);
    check("sat clear running", 32'(bus_s.running_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      drive_s(0, 0, 0, 1, 2'(i));
      tick();
      check($sformatf("sat cleared sel%0d", i), 32'(bus_s.rd_data_o), 32'd0);
    end
    drive_s(0, 0, 0, 0, 2'd0);

    // Asynchronous reset between edges in the middle of a run.
    drive(0, 0, 0, 0, 0, 1, 0, 2'd0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 2'd0);
    tick();
    tick();
    tick();
    drive(1, 0, 0, 0, 0, 0, 1, 2'd0);
    tick();
    check("pre-reset read", bus.rd_data_o, 32'd2);
    check("pre-reset running", 32'(bus.running_o), 32'd1);
    #3 rst_i = 1'b0;
    #1;
    check_zero("mid-run reset");
    #2 rst_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1, 2'd0);
    tick();
    check("post-reset read", bus.rd_data_o, 32'd0);
    check("post-reset running", 32'(bus.running_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
